// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner.
//   scan_state_t : debounce FSM states
//   frame_res_t  : classification of one complete scan frame
//   classify()   : maps a saturated hit count (0, 1, 2 = "two or more") to a result
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_res_t;

  function automatic frame_res_t classify(input logic [1:0] hits);
    frame_res_t res;
    unique case (hits)
      2'd0:    res = NONE;
      2'd1:    res = SINGLE;
      default: res = MULTI;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle enable pulse every DIV clocks.
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset
//   tick  out : high in the cycle the counter equals DIV-1 (enable, not a clock)
module scan_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Single-clock matrix keypad scanner with frame-level debounce.
//   clk         in  : system clock
//   rst_n       in  : asynchronous active-low reset
//   row_n       in  : raw row pins, active-low, asynchronous to clk
//   col         out : one-hot column drive, active-high
//   key_code    out : event code = row*COLS + col
//   key_release out : 0 = press, 1 = release
//   key_valid   out : event available
//   key_ready   in  : consumer handshake
//   overrun     out : sticky, an event was dropped while the register was full
//
// FSM (evaluated once per frame end):
//   state      | meaning
//   IDLE       | no key accepted, waiting for a SINGLE frame
//   PRESS_PEND | same single key seen cnt frames in a row
//   HELD       | press reported, waiting for an empty frame
//   REL_PEND   | empty frames seen cnt times in a row
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overrun
);

  localparam int unsigned CIW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CIW-1:0]   LAST_COL = CIW'(COLS - 1);
  localparam logic [CNT_W-1:0] DB_CNT   = CNT_W'(DEBOUNCE);

  logic tick;

  logic [ROWS-1:0]   sync1_q, sync2_q;
  logic [COLS-1:0]   col_q, col_d;
  logic [CIW-1:0]    col_idx_q, col_idx_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] key_q, key_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              rel_q, rel_d;
  logic              ovr_q, ovr_d;

  logic [ROWS-1:0]   rows_act;
  logic [1:0]        slot_n;
  int unsigned       slot_row;
  logic [CODE_W-1:0] slot_code;
  logic [2:0]        sum3;
  logic [1:0]        hits;
  logic [CODE_W-1:0] frame_code;
  frame_res_t        frame_res;
  logic              frame_end;
  logic [CNT_W-1:0]  cnt_inc;
  logic              emit, emit_rel;
  logic              accept, drop;

  scan_tick #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Per-slot sample plus running frame summary. The accumulator only needs
  // "how many hits so far (saturating at two)" and the code of the first one.
  always_comb begin
    rows_act = ~sync2_q;
    slot_n   = 2'd0;
    slot_row = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_act[r]) begin
        slot_row = r;
        if (slot_n != 2'd2) slot_n = slot_n + 2'd1;
      end
    end
    slot_code  = CODE_W'(slot_row * COLS + 32'(col_idx_q));
    sum3       = {1'b0, acc_cnt_q} + {1'b0, slot_n};
    hits       = (sum3 >= 3'd2) ? 2'd2 : sum3[1:0];
    frame_code = (acc_cnt_q == 2'd1) ? acc_code_q : slot_code;
    frame_res  = classify(hits);
    frame_end  = tick && (col_idx_q == LAST_COL);

    col_d      = col_q;
    col_idx_d  = col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      col_d     = {col_q[COLS-2:0], col_q[COLS-1]};
      col_idx_d = (col_idx_q == LAST_COL) ? '0 : col_idx_q + 1'b1;
      if (frame_end) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = hits;
        acc_code_d = frame_code;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    emit     = 1'b0;
    emit_rel = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (frame_res == SINGLE) begin
            key_d = frame_code;
            if (DEBOUNCE == 1) begin
              emit    = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = PRESS_PEND;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PRESS_PEND: begin
          if (frame_res == SINGLE && frame_code == key_q) begin
            if (cnt_inc == DB_CNT) begin
              emit    = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (frame_res == NONE) begin
            if (DEBOUNCE == 1) begin
              emit     = 1'b1;
              emit_rel = 1'b1;
              state_d  = IDLE;
              cnt_d    = '0;
            end else begin
              state_d = REL_PEND;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        REL_PEND: begin
          if (frame_res == NONE) begin
            if (cnt_inc == DB_CNT) begin
              emit     = 1'b1;
              emit_rel = 1'b1;
              state_d  = IDLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // One-entry output register. A drop can only happen when the consumer is
  // not ready, so it never coincides with an acceptance.
  always_comb begin
    accept  = valid_q && key_ready;
    drop    = emit && valid_q && !key_ready;
    valid_d = valid_q;
    code_d  = code_q;
    rel_d   = rel_q;
    ovr_d   = ovr_q;
    if (emit && !drop) begin
      valid_d = 1'b1;
      code_d  = key_d;
      rel_d   = emit_rel;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (drop)        ovr_d = 1'b1;
    else if (accept) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      col_q      <= COLS'(1);
      col_idx_q  <= '0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      rel_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= row_n;
      sync2_q    <= sync1_q;
      col_q      <= col_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      rel_q      <= rel_d;
      ovr_q      <= ovr_d;
    end
  end

  assign col         = col_q;
  assign key_code    = code_q;
  assign key_release = rel_q;
  assign key_valid   = valid_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int DB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b0, rst35 = 1'b0;
  logic       ready = 1'b1;
  logic [4:0] pressed [5];

  logic [3:0] rn4, col4, code4;
  logic       rel4, valid4, ovr4;
  logic [2:0] rn35;
  logic [4:0] col35;
  logic [3:0] code35;
  logic       rel35, valid35, ovr35;

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DB)) u_dut4 (
    .clk(clk), .rst_n(rst4), .row_n(rn4), .col(col4), .key_code(code4),
    .key_release(rel4), .key_valid(valid4), .key_ready(ready), .overrun(ovr4)
  );

  keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(4), .DEBOUNCE(DB)) u_dut35 (
    .clk(clk), .rst_n(rst35), .row_n(rn35), .col(col35), .key_code(code35),
    .key_release(rel35), .key_valid(valid35), .key_ready(ready), .overrun(ovr35)
  );

  // Ideal switch matrix: a row pin is pulled low when a pressed key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rn4[r] = 1'b1;
      for (int c = 0; c < 4; c++) if (pressed[r][c] && col4[c]) rn4[r] = 1'b0;
    end
    for (int r = 0; r < 3; r++) begin
      rn35[r] = 1'b1;
      for (int c = 0; c < 5; c++) if (pressed[r][c] && col35[c]) rn35[r] = 1'b0;
    end
  end

  int total = 0, bad = 0;
  int sel = 0, nrows = 4, ncols = 4, frame_len = 16;

  // Reference model: key status and streak of confirming frames, plus the event slot.
  bit m_held;
  int m_streak, m_cand;
  bit m_sv, m_srel, m_ov;
  int m_scode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 5; r++) pressed[r] = 5'b0;
  endtask

  task automatic set_key(input int r, input int c);
    clear_keys();
    pressed[r][c] = 1'b1;
  endtask

  task automatic model_reset();
    m_held = 0; m_streak = 0; m_cand = 0;
    m_sv = 0; m_srel = 0; m_ov = 0; m_scode = 0;
  endtask

  task automatic model_step();
    int n, code;
    bit ev, ev_rel;
    n = 0; code = 0; ev = 0; ev_rel = 0;
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < ncols; c++)
        if (pressed[r][c]) begin n++; code = r * ncols + c; end
    if (!m_held) begin
      if (m_streak == 0) begin
        if (n == 1) begin m_cand = code; m_streak = 1; end
      end else if (n == 1 && code == m_cand) m_streak++;
      else m_streak = 0;
      if (m_streak == DB) begin ev = 1; m_held = 1; m_streak = 0; end
    end else begin
      if (n == 0) m_streak++;
      else        m_streak = 0;
      if (m_streak == DB) begin ev = 1; ev_rel = 1; m_held = 0; m_streak = 0; end
    end
    // ready is held for the whole frame, so a waiting event is taken early in it
    if (ready && m_sv) begin m_sv = 0; m_ov = 0; end
    if (ev) begin
      if (!m_sv) begin m_sv = 1; m_scode = m_cand; m_srel = ev_rel; end
      else m_ov = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic v, rl, ov;
    logic [3:0] cd;
    if (sel == 0) begin v = valid4;  rl = rel4;  ov = ovr4;  cd = code4;  end
    else          begin v = valid35; rl = rel35; ov = ovr35; cd = code35; end
    chk({tag, "_valid"}, 32'(v), 32'(m_sv));
    chk({tag, "_ovr"}, 32'(ov), 32'(m_ov));
    if (m_sv) begin
      chk({tag, "_code"}, 32'(cd), 32'(m_scode));
      chk({tag, "_rel"}, 32'(rl), 32'(m_srel));
    end
  endtask

  task automatic run_frame(input string tag);
    repeat (frame_len) @(posedge clk);
    #1;
    model_step();
    check_outputs(tag);
  endtask

  task automatic do_reset(input int s);
    sel = s;
    nrows = (s == 0) ? 4 : 3;
    ncols = (s == 0) ? 4 : 5;
    frame_len = ncols * 4;
    rst4 = 1'b0; rst35 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (s == 0) rst4 = 1'b1; else rst35 = 1'b1;
    model_reset();
  endtask

  task automatic random_frames(input int nframes);
    int kr, kc;
    kr = 0; kc = 0;
    for (int i = 0; i < nframes; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      clear_keys();
      if (kind >= 3 && kind <= 7) begin
        if ($urandom_range(0, 1) == 0) begin
          kr = $urandom_range(0, nrows - 1);
          kc = $urandom_range(0, ncols - 1);
        end
        pressed[kr][kc] = 1'b1;
      end else if (kind >= 8) begin
        int r2, c2;
        r2 = $urandom_range(0, nrows - 1);
        c2 = $urandom_range(0, ncols - 1);
        pressed[r2][c2] = 1'b1;
        pressed[(r2 + 1) % nrows][$urandom_range(0, ncols - 1)] = 1'b1;
      end
      ready = ($urandom_range(0, 3) != 0);
      run_frame("rand");
    end
  endtask

  initial begin
    clear_keys();
    ready = 1'b1;

    // ---------------- 4x4 ----------------
    do_reset(0);
    #1;
    chk("rst_col4", 32'(col4), 32'h1);
    check_outputs("rst");

    set_key(2, 1);
    for (int f = 0; f < 5; f++) run_frame("press9");
    clear_keys();
    for (int f = 0; f < 3; f++) run_frame("rel9");

    set_key(2, 1);
    run_frame("bounce");
    clear_keys();
    run_frame("bounce_rel");
    run_frame("bounce_idle");

    clear_keys();
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    for (int f = 0; f < 3; f++) run_frame("multi");
    clear_keys();
    run_frame("multi_rel");

    // back-pressure: press loaded, release dropped, then drained
    ready = 1'b0;
    set_key(2, 1);
    for (int f = 0; f < 3; f++) run_frame("bp_press");
    clear_keys();
    for (int f = 0; f < 2; f++) run_frame("bp_rel");
    ready = 1'b1;
    run_frame("bp_drain");

    // reset while a press is pending and an event plus overrun are held
    ready = 1'b0;
    set_key(2, 1);
    for (int f = 0; f < 2; f++) run_frame("pre_rst_press");
    clear_keys();
    for (int f = 0; f < 2; f++) run_frame("pre_rst_rel");
    set_key(2, 1);
    run_frame("pre_rst_pend");
    repeat (5) @(posedge clk);
    #1;
    rst4 = 1'b0;
    #1;
    chk("mid_rst_col", 32'(col4), 32'h1);
    chk("mid_rst_valid", 32'(valid4), 32'h0);
    chk("mid_rst_ovr", 32'(ovr4), 32'h0);
    chk("mid_rst_code", 32'(code4), 32'h0);
    chk("mid_rst_rel", 32'(rel4), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_col_hold", 32'(col4), 32'h1);
    @(negedge clk);
    rst4 = 1'b1;
    model_reset();
    ready = 1'b1;
    run_frame("post_rst_1");
    run_frame("post_rst_2");
    clear_keys();
    for (int f = 0; f < 3; f++) run_frame("post_rst_rel");

    random_frames(40);

    // ---------------- 3x5 ----------------
    clear_keys();
    ready = 1'b1;
    do_reset(1);
    #1;
    chk("rst_col35", 32'(col35), 32'h1);
    repeat (16) @(posedge clk);
    #1;
    chk("col35_last", 32'(col35), 32'h10);
    repeat (4) @(posedge clk);
    #1;
    chk("col35_wrap", 32'(col35), 32'h1);
    model_step();
    check_outputs("f0_35");

    set_key(2, 4);
    for (int f = 0; f < 3; f++) run_frame("press14");
    clear_keys();
    for (int f = 0; f < 3; f++) run_frame("rel14");
    set_key(1, 3);
    for (int f = 0; f < 3; f++) run_frame("press8");
    clear_keys();
    for (int f = 0; f < 3; f++) run_frame("rel8");

    random_frames(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner that replaces the derived-clock scan path with a single-clock design. It drives one column at a time using a clock-enable tick, synchronises and debounces the row inputs over whole scan frames, and emits press and release events. Events leave through a one-entry valid/ready output register. The block sits between the keypad pins and the digit-entry logic and supports any ROWS×COLS matrix.

## Interface
- ROWS, 4: number of keypad rows.
- COLS, 4: number of keypad columns.
- SCAN_DIV, 100000: clk cycles per column slot; must be ≥ 4.
- DEBOUNCE, 4: consecutive identical frames required to accept a press or a release; must be ≥ 1.
- CODE_W, $clog2(ROWS*COLS): key code width (derived).

- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- row_n  in  ROWS  raw row pins, active-low (pulled up), asynchronous to clk.
- col  out  COLS  column drive, one-hot, active-high.
- key_code  out  CODE_W  event key code = row_index*COLS + col_index.
- key_release  out  1  event type: 0 = press, 1 = release.
- key_valid  out  1  event available.
- key_ready  in  1  consumer accepts the event when key_valid && key_ready.
- overrun  out  1  sticky flag: at least one event was dropped.

## Operation
- row_n passes through a 2-flop synchroniser, then is inverted to give rows active-high.
- Divider counts 0..SCAN_DIV-1. tick is asserted in the cycle the counter equals SCAN_DIV-1.
- On tick:
  - sample the synchronised rows for the currently driven column;
  - advance col by rotating left (wraps from column COLS-1 to column 0).
- One frame is COLS slots, starting at column 0. At the end of the slot for column COLS-1, the frame result is:
  - NONE: no row bit set in any column;
  - SINGLE(code): exactly one row/column bit set;
  - MULTI: any other pattern (ghosting or chording).
- FSM states and transitions (evaluated once per frame):
  - IDLE:
    - SINGLE(c) → PRESS_PEND, latch c, cnt = 1.
    - NONE or MULTI → stay in IDLE.
  - PRESS_PEND:
    - SINGLE(same c) → cnt+1; when cnt reaches DEBOUNCE, emit press(c) and go to HELD.
    - Any other result → IDLE.
    - If DEBOUNCE = 1, the first SINGLE frame goes straight from IDLE to HELD and emits the press.
  - HELD:
    - SINGLE(same c) or MULTI → stay in HELD.
    - NONE → REL_PEND, cnt = 1 (with DEBOUNCE = 1, emit release(c) and go to IDLE instead).
    - SINGLE(other c) → stay in HELD (no event).
  - REL_PEND:
    - NONE → cnt+1; when cnt reaches DEBOUNCE, emit release(c) and go to IDLE.
    - Any other result → HELD.
- Output register:
  - An emitted event loads key_code and key_release and sets key_valid.
  - Payload stays stable while key_valid && !key_ready.
  - Acceptance and a new event in the same cycle: the new event loads and key_valid stays 1 (no bubble).
  - New event while key_valid && !key_ready: the new event is dropped, the held event is kept, and overrun is set.
  - overrun clears on the next acceptance, unless a drop occurs in that same cycle.

## Timing
- Reset values:
  - col = 1 (column 0 driven);
  - key_valid = 0, key_code = 0, key_release = 0, overrun = 0;
  - divider = 0, FSM = IDLE, cnt = 0;
  - synchroniser flops = all 1 (keys released).
- rst_n is asserted asynchronously and released synchronously in the user's reset tree. Reset mid-frame or mid-debounce discards all partial state.
- Input-to-sample latency is 2 cycles (synchroniser). The sample is taken SCAN_DIV-1 cycles after the column changes.
- A key pressed stably before a frame starts gives key_valid = 1 exactly one cycle after the DEBOUNCE-th qualifying frame-end tick.
- Frame period is COLS*SCAN_DIV cycles.
- Minimum debounce time is DEBOUNCE frames.

## Structure
- keypad_pkg holds:
  - scan_state_t enum: IDLE, PRESS_PEND, HELD, REL_PEND;
  - frame_res_t enum: NONE, SINGLE, MULTI.
- Sub-module scan_tick (parameter DIV): free-running counter with a 1-cycle tick output. It is an enable only, never a clock.
- The top level holds the synchroniser, column rotator, frame accumulator, FSM and output register.

## Test plan
All scenarios use ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2 unless stated.

- Hold row 2 / column 1 pressed for 5 frames with key_ready = 1 → exactly one press event with key_code = 9 and key_release = 0, emitted at the end of frame 2.
- Release that key, then idle 3 frames → one release event with code 9, emitted 2 frames after the last pressed frame.
- Press the key for 1 frame, then release (bounce) → no events; FSM returns to IDLE.
- Press rows 0 and 1 on column 0 together from IDLE → no event (MULTI ignored).
- key_ready = 0 while a press and a release are both emitted → key_valid = 1, code 9 press held, and overrun = 1. On key_ready = 1 the press is accepted, then key_valid = 0 and overrun = 0.
- Assert rst_n low during PRESS_PEND → on the next cycle all outputs are at reset values and col = 0001.
- Rerun with ROWS = 3, COLS = 5 → codes map to row*5 + col and col wraps from 10000 to 00001.
